// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI-Lite slave between a read-only IFU (M0) and an LSU (M1).
// One transaction in flight; grant is held until the response handshake, then re-arbitrated.
module axi_lite_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_arvalid,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic [2:0]          m0_arsize,
   output logic                m0_arready,
   output logic                m0_rvalid,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   input  logic                m0_rready,
   input  logic                m1_arvalid,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic [2:0]          m1_arsize,
   output logic                m1_arready,
   output logic                m1_rvalid,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   input  logic                m1_rready,
   input  logic                m1_awvalid,
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [2:0]          m1_awsize,
   output logic                m1_awready,
   input  logic                m1_wvalid,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_wready,
   output logic                m1_bvalid,
   output logic [1:0]          m1_bresp,
   input  logic                m1_bready,
   output logic                s_arvalid,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic [2:0]          s_arsize,
   input  logic                s_arready,
   input  logic                s_rvalid,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   output logic                s_rready,
   output logic                s_awvalid,
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic [2:0]          s_awsize,
   input  logic                s_awready,
   output logic                s_wvalid,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wready,
   input  logic                s_bvalid,
   input  logic [1:0]          s_bresp,
   output logic                s_bready
);
   typedef enum logic [1:0] {IDLE, M0_RD, M1_RD, M1_WR} state_t;
   state_t state, state_n;
   logic last_grant, a_done, w_done, protocol_err_q;
   logic req0, req1r, req1w, pick1, g0, g1r, g1w, rd_end, wr_end;

   assign req0  = m0_arvalid;
   assign req1r = m1_arvalid;
   assign req1w = m1_awvalid | m1_wvalid;
   // On contention M1 wins unless round-robin says it was served last.
   assign pick1 = (req1r | req1w) & (~req0 | (RR_EN == 1'b0) | ~last_grant);
   assign g0  = state == M0_RD;
   assign g1r = state == M1_RD;
   assign g1w = state == M1_WR;
   assign rd_end = (g0 | g1r) & s_rvalid & s_rready;
   assign wr_end = g1w & s_bvalid & s_bready;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_n;

   always_comb
      state_n = (state == IDLE) ? (pick1 ? (req1r ? M1_RD : M1_WR) : (req0 ? M0_RD : IDLE))
              : (rd_end | wr_end) ? IDLE : state;

   // Address and write-data phases are accepted once per grant.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         last_grant     <= 1'b1;
         a_done         <= 1'b0;
         w_done         <= 1'b0;
         protocol_err_q <= 1'b0;
      end else begin
         if (state == IDLE && (req0 | req1r | req1w)) last_grant <= pick1;
         a_done         <= (state != IDLE) & (a_done | (s_arvalid & s_arready) | (s_awvalid & s_awready));
         w_done         <= g1w & (w_done | (s_wvalid & s_wready));
         protocol_err_q <= (s_rvalid & ~(g0 | g1r)) | (s_bvalid & ~g1w);
      end

   always @(posedge clk)
      if (!rst) assert (!protocol_err_q);

   always_comb begin
      s_arvalid  = ~a_done & ((g0 & m0_arvalid) | (g1r & m1_arvalid));
      s_araddr   = g0 ? m0_araddr : g1r ? m1_araddr : '0;
      s_arsize   = g0 ? m0_arsize : g1r ? m1_arsize : 3'd0;
      m0_arready = g0 & ~a_done & s_arready;
      m1_arready = g1r & ~a_done & s_arready;
      s_rready   = (g0 & m0_rready) | (g1r & m1_rready);
      m0_rvalid  = g0 & s_rvalid;
      m0_rdata   = g0 ? s_rdata : '0;
      m0_rresp   = g0 ? s_rresp : 2'b00;
      m1_rvalid  = g1r & s_rvalid;
      m1_rdata   = g1r ? s_rdata : '0;
      m1_rresp   = g1r ? s_rresp : 2'b00;
      s_awvalid  = g1w & ~a_done & m1_awvalid;
      s_awaddr   = g1w ? m1_awaddr : '0;
      s_awsize   = g1w ? m1_awsize : 3'd0;
      m1_awready = g1w & ~a_done & s_awready;
      s_wvalid   = g1w & ~w_done & m1_wvalid;
      s_wdata    = g1w ? m1_wdata : '0;
      s_wstrb    = g1w ? m1_wstrb : '0;
      m1_wready  = g1w & ~w_done & s_wready;
      s_bready   = g1w & m1_bready;
      m1_bvalid  = g1w & s_bvalid;
      m1_bresp   = g1w ? s_bresp : 2'b00;
   end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: random traffic against a pending-request model; one RR and one fixed-priority instance.
module tb_axi_lite_arbiter;
   logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
   always #5 clk = ~clk;

   logic m0_arvalid = 0, m0_rready = 1, m1_arvalid = 0, m1_rready = 1;
   logic m1_awvalid = 0, m1_wvalid = 0, m1_bready = 1;
   logic [31:0] m0_araddr = 0, m1_araddr = 0, m1_awaddr = 0, m1_wdata = 0, s_rdata = 0;
   logic [2:0] m0_arsize = 0, m1_arsize = 0, m1_awsize = 0;
   logic [3:0] m1_wstrb = 0;
   logic s_arready = 0, s_rvalid = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
   logic [1:0] s_rresp = 0, s_bresp = 0;

   logic m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
   logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
   logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
   logic [1:0] m0_rresp, m1_rresp, m1_bresp;
   logic [2:0] s_arsize, s_awsize;
   logic [3:0] s_wstrb;

   logic m0_arready_a [2], m0_rvalid_a [2], m1_arready_a [2], m1_rvalid_a [2];
   logic m1_awready_a [2], m1_wready_a [2], m1_bvalid_a [2];
   logic s_arvalid_a [2], s_rready_a [2], s_awvalid_a [2], s_wvalid_a [2], s_bready_a [2];
   logic [31:0] m0_rdata_a [2], m1_rdata_a [2], s_araddr_a [2], s_awaddr_a [2], s_wdata_a [2];
   logic [1:0] m0_rresp_a [2], m1_rresp_a [2], m1_bresp_a [2];
   logic [2:0] s_arsize_a [2], s_awsize_a [2];
   logic [3:0] s_wstrb_a [2];

   for (genvar g = 0; g < 2; g++) begin : u
      logic act;
      assign act = int'(sel) == g;
      axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(g == 0)) dut (
         .clk(clk), .rst(rst),
         .m0_arvalid(m0_arvalid & act), .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
         .m0_arready(m0_arready_a[g]),
         .m0_rvalid(m0_rvalid_a[g]), .m0_rdata(m0_rdata_a[g]), .m0_rresp(m0_rresp_a[g]),
         .m0_rready(m0_rready & act),
         .m1_arvalid(m1_arvalid & act), .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
         .m1_arready(m1_arready_a[g]),
         .m1_rvalid(m1_rvalid_a[g]), .m1_rdata(m1_rdata_a[g]), .m1_rresp(m1_rresp_a[g]),
         .m1_rready(m1_rready & act),
         .m1_awvalid(m1_awvalid & act), .m1_awaddr(m1_awaddr), .m1_awsize(m1_awsize),
         .m1_awready(m1_awready_a[g]),
         .m1_wvalid(m1_wvalid & act), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
         .m1_wready(m1_wready_a[g]),
         .m1_bvalid(m1_bvalid_a[g]), .m1_bresp(m1_bresp_a[g]), .m1_bready(m1_bready & act),
         .s_arvalid(s_arvalid_a[g]), .s_araddr(s_araddr_a[g]), .s_arsize(s_arsize_a[g]),
         .s_arready(s_arready & act),
         .s_rvalid(s_rvalid & act), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready_a[g]),
         .s_awvalid(s_awvalid_a[g]), .s_awaddr(s_awaddr_a[g]), .s_awsize(s_awsize_a[g]),
         .s_awready(s_awready & act),
         .s_wvalid(s_wvalid_a[g]), .s_wdata(s_wdata_a[g]), .s_wstrb(s_wstrb_a[g]),
         .s_wready(s_wready & act),
         .s_bvalid(s_bvalid & act), .s_bresp(s_bresp), .s_bready(s_bready_a[g])
      );
   end

   assign m0_arready = m0_arready_a[sel];
   assign m0_rvalid  = m0_rvalid_a[sel];
   assign m0_rdata   = m0_rdata_a[sel];
   assign m0_rresp   = m0_rresp_a[sel];
   assign m1_arready = m1_arready_a[sel];
   assign m1_rvalid  = m1_rvalid_a[sel];
   assign m1_rdata   = m1_rdata_a[sel];
   assign m1_rresp   = m1_rresp_a[sel];
   assign m1_awready = m1_awready_a[sel];
   assign m1_wready  = m1_wready_a[sel];
   assign m1_bvalid  = m1_bvalid_a[sel];
   assign m1_bresp   = m1_bresp_a[sel];
   assign s_arvalid  = s_arvalid_a[sel];
   assign s_araddr   = s_araddr_a[sel];
   assign s_arsize   = s_arsize_a[sel];
   assign s_rready   = s_rready_a[sel];
   assign s_awvalid  = s_awvalid_a[sel];
   assign s_awaddr   = s_awaddr_a[sel];
   assign s_awsize   = s_awsize_a[sel];
   assign s_wvalid   = s_wvalid_a[sel];
   assign s_wdata    = s_wdata_a[sel];
   assign s_wstrb    = s_wstrb_a[sel];
   assign s_bready   = s_bready_a[sel];

   int n_cmp = 0, n_err = 0;
   // Reference model: pending requests per master, who was served last, arbitration mode.
   bit p0, p1r, p1w, last_g = 1'b1, rr = 1'b1;
   logic [31:0] a0, a1r, a1w, wd;
   logic [2:0] z0, z1r, z1w;
   logic [3:0] ws;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag);
      check({tag, "_hs"}, {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                           m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 0);
      check({tag, "_data"}, s_araddr | s_awaddr | s_wdata | m0_rdata | m1_rdata, 0);
      check({tag, "_ctl"}, {s_arsize, s_awsize, s_wstrb, m0_rresp, m1_rresp, m1_bresp}, 0);
   endtask

   task automatic request(input bit r0, input bit r1r, input bit r1w);
      if (r0 && !p0) begin p0 = 1; m0_arvalid = 1; m0_araddr = a0; m0_arsize = z0; end
      if (r1r && !p1r) begin p1r = 1; m1_arvalid = 1; m1_araddr = a1r; m1_arsize = z1r; end
      if (r1w && !p1w) begin
         p1w = 1; m1_awvalid = 1; m1_wvalid = 1;
         m1_awaddr = a1w; m1_awsize = z1w; m1_wdata = wd; m1_wstrb = ws;
      end
   endtask

   task automatic rnd_req();
      bit r0, r1r, r1w;
      r0 = 1'($urandom_range(0, 1));
      r1r = 1'($urandom_range(0, 1));
      r1w = 1'($urandom_range(0, 1));
      if (!p0) begin a0 = $urandom; z0 = 3'($urandom_range(0, 2)); end
      if (!p1r) begin a1r = $urandom; z1r = 3'($urandom_range(0, 2)); end
      if (!p1w) begin a1w = $urandom; z1w = 3'($urandom_range(0, 2)); wd = $urandom; ws = 4'($urandom); end
      request(r0, r1r, r1w);
   endtask

   // Called with the DUT idle and at least one request pending; returns idle after the response.
   task automatic serve_one(input logic [31:0] rd, input logic [1:0] rresp_i, input logic [1:0] bresp_i,
                            input int ta_i, input int tw_i);
      bit w, wr;
      int ta, tw;
      quiet("idle");
      w = !p0 ? 1'b1 : !(p1r || p1w) ? 1'b0 : rr ? !last_g : 1'b1;
      wr = w && !p1r;
      last_g = w;
      step();
      if (!wr) begin
         check("ar_valid", {s_arvalid, s_awvalid, s_wvalid}, 3'b100);
         check("ar_addr", s_araddr, w ? a1r : a0);
         check("ar_size", s_arsize, w ? z1r : z0);
         repeat ($urandom_range(0, 2)) step();
         s_arready = 1; #1;
         check("ar_ready", {m0_arready, m1_arready, m1_awready, m1_wready}, w ? 4'b0100 : 4'b1000);
         step();
         s_arready = 0;
         if (w) begin m1_arvalid = 0; p1r = 0; end
         else begin m0_arvalid = 0; p0 = 0; end
         repeat ($urandom_range(0, 2)) step();
         s_rvalid = 1; s_rdata = rd; s_rresp = rresp_i; #1;
         check("r_valid", {m0_rvalid, m1_rvalid, m1_bvalid, s_rready}, w ? 4'b0101 : 4'b1001);
         check("r_data", w ? m1_rdata : m0_rdata, rd);
         check("r_resp", w ? m1_rresp : m0_rresp, rresp_i);
         step();
         s_rvalid = 0; s_rdata = 0; s_rresp = 0;
      end else begin
         check("aw_w_valid", {s_awvalid, s_wvalid, s_arvalid}, 3'b110);
         check("aw_addr", s_awaddr, a1w);
         check("aw_size", s_awsize, z1w);
         check("w_data", s_wdata, wd);
         check("w_strb", s_wstrb, ws);
         ta = ta_i < 0 ? $urandom_range(0, 2) : ta_i;
         tw = tw_i < 0 ? $urandom_range(0, 2) : tw_i;
         for (int k = 0; k <= (ta > tw ? ta : tw); k++) begin
            s_awready = k == ta; s_wready = k == tw; #1;
            check("wr_ready", {m0_arready, m1_arready, m1_awready, m1_wready, m1_bvalid},
                  {2'b00, k == ta, k == tw, 1'b0});
            step();
            if (k == ta) m1_awvalid = 0;
            if (k == tw) m1_wvalid = 0;
         end
         s_awready = 0; s_wready = 0; p1w = 0;
         repeat ($urandom_range(0, 2)) step();
         s_bvalid = 1; s_bresp = bresp_i; #1;
         check("b_valid", {m1_bvalid, s_bready, m0_rvalid, m1_rvalid, m0_arready}, 5'b11000);
         check("b_resp", m1_bresp, bresp_i);
         step();
         s_bvalid = 0; s_bresp = 0;
      end
   endtask

   task automatic drain(input bit more);
      int rounds = 0;
      while (p0 || p1r || p1w) begin
         serve_one($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), -1, -1);
         if (more && rounds < 20) rnd_req();
         rounds++;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11; s_bresp = 2'b11;
      step(); step();
      quiet("reset");
      s_rdata = 0; s_rresp = 0; s_bresp = 0;
      p0 = 0; p1r = 0; p1w = 0; last_g = 1;
      rst = 0;
      step();
   endtask

   initial begin
      do_reset();
      // contention straight after reset: M0 first, then alternation
      for (int i = 0; i < 2; i++) begin
         a0 = $urandom; z0 = 3'd2; a1r = 32'h8000_1004; z1r = 3'd2;
         request(1, 1, 0);
         drain(0);
      end
      a0 = 32'h8000_0000; z0 = 3'd2;
      request(1, 0, 0);
      serve_one(32'h0000_0413, 2'b00, 2'b00, -1, -1);
      // write with aw and w two cycles apart while M0 waits
      a0 = $urandom; a1w = 32'h8000_2000; z1w = 3'd2; wd = 32'hDEAD_BEEF; ws = 4'b0011;
      request(1, 0, 1);
      serve_one(0, 2'b00, 2'b00, 0, 2);
      drain(0);
      a1r = $urandom; z1r = 3'd2;
      request(0, 1, 0);
      serve_one($urandom, 2'b10, 2'b00, -1, -1);
      a0 = $urandom;
      request(1, 0, 0);
      serve_one($urandom, 2'b00, 2'b00, -1, -1);
      for (int i = 0; i < 6; i++) begin
         rnd_req();
         drain(1);
      end
      // reset in the middle of a write, after the aw handshake
      a1w = $urandom; wd = $urandom; ws = 4'hF;
      request(0, 0, 1);
      step();
      s_awready = 1;
      step();
      m1_awvalid = 0; s_awready = 0; rst = 1; #1;
      quiet("rst_mid");
      m1_wvalid = 0; p1w = 0; last_g = 1;
      step();
      rst = 0;
      step();
      a0 = $urandom;
      request(1, 0, 0);
      serve_one($urandom, 2'b00, 2'b00, -1, -1);
      // fixed priority instance: M1 must win every contended idle
      sel = 1; rr = 0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         a0 = $urandom; a1r = $urandom; z0 = 3'd2; z1r = 3'd2;
         request(1, i % 2 == 0, 0);
         serve_one($urandom, 2'b00, 2'b00, -1, -1);
         drain(0);
      end
      for (int i = 0; i < 4; i++) begin
         rnd_req();
         drain(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master, one-slave AXI-Lite arbiter that shares the single memory/SRAM slave between the instruction fetch unit (M0, read-only) and the load/store unit (M1, read and write).
- Sits between IFU/LSU and the memory slave in the NPC top level.
- Grants exactly one outstanding transaction at a time, holds the grant until the response handshake, then re-arbitrates round-robin.

Parameters:
- ADDR_W, 32, address width of all channels.
- DATA_W, 32, data width; wstrb is DATA_W/8.
- RR_EN, 1, 1 = round-robin on contention; 0 = fixed priority, M1 wins.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- m0_ar: m0_arvalid in 1, m0_araddr in ADDR_W, m0_arsize in 3, m0_arready out 1.
- m0_r: m0_rvalid out 1, m0_rdata out DATA_W, m0_rresp out 2, m0_rready in 1.
- m1_ar: m1_arvalid in 1, m1_araddr in ADDR_W, m1_arsize in 3, m1_arready out 1.
- m1_r: m1_rvalid out 1, m1_rdata out DATA_W, m1_rresp out 2, m1_rready in 1.
- m1_aw: m1_awvalid in 1, m1_awaddr in ADDR_W, m1_awsize in 3, m1_awready out 1.
- m1_w: m1_wvalid in 1, m1_wdata in DATA_W, m1_wstrb in DATA_W/8, m1_wready out 1.
- m1_b: m1_bvalid out 1, m1_bresp out 2, m1_bready in 1.
- s_ar: s_arvalid out 1, s_araddr out ADDR_W, s_arsize out 3, s_arready in 1.
- s_r: s_rvalid in 1, s_rdata in DATA_W, s_rresp in 2, s_rready out 1.
- s_aw: s_awvalid out 1, s_awaddr out ADDR_W, s_awsize out 3, s_awready in 1.
- s_w: s_wvalid out 1, s_wdata out DATA_W, s_wstrb out DATA_W/8, s_wready in 1.
- s_b: s_bvalid in 1, s_bresp in 2, s_bready out 1.

Behaviour:
- State machine: IDLE, M0_RD, M1_RD, M1_WR. Also a registered last_grant bit (0 = M0, 1 = M1).
- Reset (async, rst=1):
  - state = IDLE, last_grant = 1.
  - All valid/ready outputs on every port are 0.
  - Data, address and resp outputs are 0.
- IDLE:
  - No channel forwarded; all readies to masters and all valids to slave are 0.
  - Requests: req0 = m0_arvalid; req1r = m1_arvalid; req1w = m1_awvalid | m1_wvalid.
  - Only req0 -> M0_RD.
  - Only an M1 request -> M1_RD if req1r, else M1_WR. If req1r and req1w are both set, the read wins and the write waits.
  - Contention with RR_EN=1: grant the master that is not last_grant. With RR_EN=0: M1 wins.
  - last_grant is updated on the IDLE->grant transition.
- Grant latency: one cycle from a valid seen in IDLE to the corresponding s_*valid. Addresses and data are forwarded combinationally from the granted master in the granted state.
- M0_RD:
  - s_ar* = m0_ar*, m0_arready = s_arready.
  - m0_r* = s_r*, s_rready = m0_rready.
  - All M1 readies and M1 response valids are 0.
  - Exit to IDLE the cycle after s_rvalid & s_rready.
- M1_RD: same forwarding as M0_RD on the M1 read channels; M0 is fully blocked. Exit on s_rvalid & s_rready.
- M1_WR:
  - aw, w and b channels are forwarded independently.
  - aw and w may handshake in the same or different cycles, in either order.
  - Exit to IDLE the cycle after s_bvalid & s_bready.
- Grant is locked until the response handshake, even if the granted master deasserts valid (which is an AXI violation by the master).
- At least one IDLE cycle separates back-to-back transactions.
- A request from the non-granted master stays pending (its ready is held 0) and is arbitrated on the next IDLE.
- rresp/bresp are passed through unchanged, including SLVERR/DECERR. The arbiter performs no address decode.
- s_rvalid or s_bvalid arriving in a state with no matching grant is ignored. A one-cycle assertion flag, protocol_err_q, is kept for simulation only; it is not a port.
- Reset mid-transaction: returns to IDLE immediately. The slave shares the same rst, so no orphaned response is expected.

Test Plan:
- M0 only: m0_araddr=0x8000_0000, slave returns 0x0000_0413 after 2 cycles -> s_arvalid rises 1 cycle after m0_arvalid; m0_rdata=0x0000_0413, rresp=0; state back to IDLE; m1_arready stays 0 throughout.
- Contention after reset (last_grant=1): m0_arvalid and m1_arvalid in the same cycle -> M0 granted first. M1 is granted on the next IDLE, with s_araddr = m1_araddr = 0x8000_1004. Repeat -> grants alternate.
- M1 write with aw accepted at cycle t and w at t+2: m1_awaddr=0x8000_2000, wdata=0xDEAD_BEEF, wstrb=4'b0011 -> s_wdata/s_wstrb match exactly. m1_bvalid is seen only after both handshakes; during this, m0_arready=0 even with m0_arvalid=1.
- Error pass-through: slave returns rresp=2'b10 to M1 -> m1_rresp=2'b10; next M0 read is still served normally.
- RR_EN=0 with continuous m0_arvalid and periodic m1_arvalid -> M1 is granted at every contended IDLE.
- Assert rst during M1_WR after aw handshake -> all outputs 0 within the same cycle; after release, an M0 read completes normally.
